// File: rtl/mem_decoder_pkg.sv
// Shared encodings for the mem_decoder address demux: FSM states, target selection
// and the default error read-data pattern.
package mem_decoder_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    SEL_DEV0 = 2'd0,
    SEL_DEV1 = 2'd1,
    SEL_DEV2 = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

  localparam logic [31:0] UNMAPPED_DATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic logic [2:0] sel_onehot(input sel_e sel);
    logic [2:0] oh;
    case (sel)
      SEL_DEV0: oh = 3'b001;
      SEL_DEV1: oh = 3'b010;
      SEL_DEV2: oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mem_decoder_match.sv
// Combinational base/mask window comparator; one instance per downstream target.
module mem_decoder_match #(
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter logic [31:0] MASK = 32'hFFFF_0000
) (
  input  logic [31:0] addr,
  output logic        hit
);

  assign hit = ((addr & MASK) == BASE);

endmodule

// File: rtl/mem_decoder.sv
// Registered address decoder splitting one valid/ready initiator across three targets.
// Optional build macro MEM_DECODER_TIMEOUT_EN adds an ACCESS-state timeout abort.
module mem_decoder
  import mem_decoder_pkg::*;
#(
  parameter logic [31:0] DEV0_BASE      = 32'h0000_0000,
  parameter logic [31:0] DEV0_MASK      = 32'hFFFF_0000,
  parameter logic [31:0] DEV1_BASE      = 32'h1000_0000,
  parameter logic [31:0] DEV1_MASK      = 32'hFFFF_F000,
  parameter logic [31:0] DEV2_BASE      = 32'h2000_0000,
  parameter logic [31:0] DEV2_MASK      = 32'hFF00_0000,
  parameter logic [31:0] UNMAPPED_DATA  = UNMAPPED_DATA_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        dev0_valid,
  input  logic        dev0_ready,
  output logic [31:0] dev0_addr,
  input  logic [31:0] dev0_rdata,
  output logic [31:0] dev0_wdata,
  output logic [3:0]  dev0_wstrb,
  output logic        dev1_valid,
  input  logic        dev1_ready,
  output logic [31:0] dev1_addr,
  input  logic [31:0] dev1_rdata,
  output logic [31:0] dev1_wdata,
  output logic [3:0]  dev1_wstrb,
  output logic        dev2_valid,
  input  logic        dev2_ready,
  output logic [31:0] dev2_addr,
  input  logic [31:0] dev2_rdata,
  output logic [31:0] dev2_wdata,
  output logic [3:0]  dev2_wstrb,
  output logic        bus_err
);

  logic [2:0]  hit_s;
  sel_e        sel_s, sel_r, sel_n_s;
  logic [1:0]  state_r, state_n_s;
  logic [31:0] addr_r, addr_n_s, wdata_r, wdata_n_s, resp_r, resp_n_s, rdata_r;
  logic [3:0]  wstrb_r, wstrb_n_s;
  logic        bus_err_r, bus_err_n_s, ready_r;
  logic [2:0]  valid_r;
  logic        tgt_ready_s, timeout_s;
  logic [31:0] tgt_rdata_s;

  mem_decoder_match #(.BASE(DEV0_BASE), .MASK(DEV0_MASK)) u_match0 (.addr(mem_addr), .hit(hit_s[0]));
  mem_decoder_match #(.BASE(DEV1_BASE), .MASK(DEV1_MASK)) u_match1 (.addr(mem_addr), .hit(hit_s[1]));
  mem_decoder_match #(.BASE(DEV2_BASE), .MASK(DEV2_MASK)) u_match2 (.addr(mem_addr), .hit(hit_s[2]));

  // Overlapping windows resolve to the lowest-numbered target.
  always_comb begin
    if (hit_s[0])      sel_s = SEL_DEV0;
    else if (hit_s[1]) sel_s = SEL_DEV1;
    else if (hit_s[2]) sel_s = SEL_DEV2;
    else               sel_s = SEL_NONE;
  end

  always_comb begin
    case (sel_r)
      SEL_DEV0: begin tgt_ready_s = dev0_ready; tgt_rdata_s = dev0_rdata; end
      SEL_DEV1: begin tgt_ready_s = dev1_ready; tgt_rdata_s = dev1_rdata; end
      SEL_DEV2: begin tgt_ready_s = dev2_ready; tgt_rdata_s = dev2_rdata; end
      default:  begin tgt_ready_s = 1'b0;       tgt_rdata_s = 32'h0000_0000; end
    endcase
  end

`ifdef MEM_DECODER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r;

  // Counter is held at zero outside ACCESS, so every access starts from a clean count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     cnt_r <= '0;
    else if (state_r != ST_ACCESS) cnt_r <= '0;
    else                           cnt_r <= cnt_r + CNT_W'(1'b1);
  end

  assign timeout_s = (state_r == ST_ACCESS) && ((cnt_r + CNT_W'(1'b1)) == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic; a target ready in the timeout cycle takes precedence over the abort.
  always_comb begin
    state_n_s   = state_r;
    sel_n_s     = sel_r;
    addr_n_s    = addr_r;
    wdata_n_s   = wdata_r;
    wstrb_n_s   = wstrb_r;
    resp_n_s    = resp_r;
    bus_err_n_s = bus_err_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_valid) begin
          sel_n_s   = sel_s;
          addr_n_s  = mem_addr;
          wdata_n_s = mem_wdata;
          wstrb_n_s = mem_wstrb;
          if (sel_s == SEL_NONE) begin
            state_n_s   = ST_DONE;
            resp_n_s    = UNMAPPED_DATA;
            bus_err_n_s = 1'b1;
          end else begin
            state_n_s = ST_ACCESS;
          end
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (tgt_ready_s) begin
          state_n_s = ST_DONE;
          resp_n_s  = tgt_rdata_s;
        end else if (timeout_s) begin
          state_n_s   = ST_DONE;
          resp_n_s    = UNMAPPED_DATA;
          bus_err_n_s = 1'b1;
        end else begin
          state_n_s = ST_ACCESS;
        end
      end
      ST_DONE: state_n_s = ST_IDLE;
      default: state_n_s = ST_IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      sel_r     <= SEL_NONE;
      addr_r    <= 32'h0000_0000;
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'h0;
      resp_r    <= 32'h0000_0000;
      bus_err_r <= 1'b0;
      ready_r   <= 1'b0;
      rdata_r   <= 32'h0000_0000;
      valid_r   <= 3'b000;
    end else begin
      state_r   <= state_n_s;
      sel_r     <= sel_n_s;
      addr_r    <= addr_n_s;
      wdata_r   <= wdata_n_s;
      wstrb_r   <= wstrb_n_s;
      resp_r    <= resp_n_s;
      bus_err_r <= bus_err_n_s;
      ready_r   <= (state_n_s == ST_DONE);
      rdata_r   <= (state_n_s == ST_DONE) ? resp_n_s : 32'h0000_0000;
      valid_r   <= (state_n_s == ST_ACCESS) ? sel_onehot(sel_n_s) : 3'b000;
    end
  end

  assign mem_ready  = ready_r;
  assign mem_rdata  = rdata_r;
  assign bus_err    = bus_err_r;
  assign dev0_valid = valid_r[0];
  assign dev1_valid = valid_r[1];
  assign dev2_valid = valid_r[2];
  assign dev0_addr  = addr_r;
  assign dev1_addr  = addr_r;
  assign dev2_addr  = addr_r;
  assign dev0_wdata = wdata_r;
  assign dev1_wdata = wdata_r;
  assign dev2_wdata = wdata_r;
  assign dev0_wstrb = wstrb_r;
  assign dev1_wstrb = wstrb_r;
  assign dev2_wstrb = wstrb_r;

endmodule

// File: tb/tb_mem_decoder.sv
// Self-checking bench for mem_decoder: directed scenarios plus randomized transactions
// checked against an address-range reference model and cycle-accurate latency rules.
module tb_mem_decoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [2:0]  dev_valid, dev_ready;
  logic [31:0] dev_addr [3];
  logic [31:0] dev_rdata [3];
  logic [31:0] dev_wdata [3];
  logic [3:0]  dev_wstrb [3];
  logic        bus_err;
  logic        bus_err_exp = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_decoder dut (
    .clk(clk), .rstn(rstn),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .dev0_valid(dev_valid[0]), .dev0_ready(dev_ready[0]), .dev0_addr(dev_addr[0]),
    .dev0_rdata(dev_rdata[0]), .dev0_wdata(dev_wdata[0]), .dev0_wstrb(dev_wstrb[0]),
    .dev1_valid(dev_valid[1]), .dev1_ready(dev_ready[1]), .dev1_addr(dev_addr[1]),
    .dev1_rdata(dev_rdata[1]), .dev1_wdata(dev_wdata[1]), .dev1_wstrb(dev_wstrb[1]),
    .dev2_valid(dev_valid[2]), .dev2_ready(dev_ready[2]), .dev2_addr(dev_addr[2]),
    .dev2_rdata(dev_rdata[2]), .dev2_wdata(dev_wdata[2]), .dev2_wstrb(dev_wstrb[2]),
    .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode as address ranges: 0 RAM, 1 ROM, 2 peripherals, 3 unmapped.
  function automatic int exp_target(input logic [31:0] a);
    if (a < 32'h0001_0000) return 0;
    if (a >= 32'h1000_0000 && a < 32'h1000_1000) return 1;
    if (a >= 32'h2000_0000 && a < 32'h2100_0000) return 2;
    return 3;
  endfunction

  task automatic idle(input int n);
    mem_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_ready", 32'(mem_ready), 32'h0);
      chk("idle_valid", 32'(dev_valid), 32'h0);
    end
  endtask

  // Issues one request (cycle 0 = current cycle); selected target answers after 'delay'
  // cycles of valid. Returns in the IDLE cycle after completion with mem_valid still high.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int delay, input logic [31:0] rd);
    int          s;
    int          rdy_cyc;
    int          exp_done;
    int          done_cyc;
    logic [2:0]  sel_oh;
    logic [31:0] exp_rdata;
    s         = exp_target(a);
    sel_oh    = (s < 3) ? (3'b001 << s) : 3'b000;
    rdy_cyc   = (s < 3) ? 1 + delay : 0;
    exp_done  = (s < 3) ? rdy_cyc + 1 : 1;
    exp_rdata = (s < 3) ? rd : 32'hDEAD_BEEF;
    done_cyc  = -1;
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    dev_ready = 3'b000;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      step();
      chk("dev_valid", 32'(dev_valid), (s < 3 && c <= rdy_cyc) ? 32'(sel_oh) : 32'h0);
      if (s < 3 && c <= rdy_cyc) begin
        chk("dev_addr", dev_addr[s], a);
        chk("dev_wdata", dev_wdata[s], wd);
        chk("dev_wstrb", 32'(dev_wstrb[s]), 32'(ws));
      end
      if (mem_ready) begin
        done_cyc = c;
        chk("mem_rdata", mem_rdata, exp_rdata);
      end else begin
        chk("rdata_zero", mem_rdata, 32'h0);
      end
      // Stray readies on other targets must be ignored.
      dev_ready = 3'($urandom) & ~sel_oh;
      for (int i = 0; i < 3; i++) dev_rdata[i] = $urandom;
      if (s < 3 && c == rdy_cyc) begin
        dev_ready[s] = 1'b1;
        dev_rdata[s] = rd;
      end
    end
    dev_ready = 3'b000;
    chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    if (s == 3) bus_err_exp = 1'b1;
    chk("bus_err", 32'(bus_err), 32'(bus_err_exp));
    step();
    chk("post_ready", 32'(mem_ready), 32'h0);
    chk("post_valid", 32'(dev_valid), 32'h0);
  endtask

  initial begin
    int          nvalid;
    int          done_cyc;
    logic [31:0] got;
    logic [31:0] ra;
    int          w;

    rstn = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    dev_ready = 3'b000;
    for (int i = 0; i < 3; i++) dev_rdata[i] = 32'h0;
    step(); step();
    chk("rst_ready", 32'(mem_ready), 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_valid", 32'(dev_valid), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_addr", dev_addr[i], 32'h0);
      chk("rst_wdata", dev_wdata[i], 32'h0);
      chk("rst_wstrb", 32'(dev_wstrb[i]), 32'h0);
    end
    @(negedge clk) rstn = 1'b1;
    step();

    run_txn(32'h0000_0040, 32'h0, 4'b0000, 1, 32'h1234_5678);
    idle(2);
    run_txn(32'h2000_0010, 32'hCAFE_F00D, 4'b0011, 3, 32'h0BAD_0BAD);
    idle(1);
    run_txn(32'h3000_0000, 32'h0, 4'b0000, 0, 32'h0);
    idle(1);
    run_txn(32'h1000_0ABC, 32'h0, 4'b0000, 2, 32'hA5A5_5A5A);
    run_txn(32'h0000_1230, 32'h1357_9BDF, 4'b1111, 0, 32'h0);
    idle(1);

    // Target that never answers.
    mem_valid = 1'b1; mem_addr = 32'h0000_0100; mem_wstrb = 4'h0;
    nvalid = 0; done_cyc = -1; got = 32'h0;
    for (int c = 1; c <= 120 && done_cyc < 0; c++) begin
      step();
      if (dev_valid[0]) nvalid++;
      if (mem_ready) begin done_cyc = c; got = mem_rdata; end
    end
`ifdef MEM_DECODER_TIMEOUT_EN
    bus_err_exp = 1'b1;
    chk("to_valid_cycles", 32'(nvalid), 32'd16);
    chk("to_done_cycle", 32'(done_cyc), 32'd17);
    chk("to_rdata", got, 32'hDEAD_BEEF);
    chk("to_bus_err", 32'(bus_err), 32'(bus_err_exp));
    idle(2);
`else
    chk("wait_valid_cycles", 32'(nvalid), 32'd120);
    chk("wait_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    chk("wait_still_valid", 32'(dev_valid), 32'h1);
    mem_valid = 1'b0;
    #2 rstn = 1'b0;
    bus_err_exp = 1'b0;
    @(negedge clk) rstn = 1'b1;
    step();
`endif

    // Reset asserted during ACCESS.
    mem_valid = 1'b1; mem_addr = 32'h1000_0004; mem_wstrb = 4'h0;
    step(); step();
    chk("pre_rst_valid", 32'(dev_valid), 32'h2);
    #2 rstn = 1'b0;
    mem_valid = 1'b0;
    bus_err_exp = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(dev_valid), 32'h0);
    chk("mid_rst_ready", 32'(mem_ready), 32'h0);
    chk("mid_rst_bus_err", 32'(bus_err), 32'h0);
    @(negedge clk) rstn = 1'b1;
    step();
    run_txn(32'h0000_0080, 32'h0, 4'b0000, 0, 32'h7777_1111);
    idle(1);

    // Randomized traffic across all windows.
    for (int n = 0; n < 30; n++) begin
      w = $urandom_range(0, 3);
      case (w)
        0:       ra = $urandom & 32'h0000_FFFF;
        1:       ra = 32'h1000_0000 | ($urandom & 32'h0000_0FFF);
        2:       ra = 32'h2000_0000 | ($urandom & 32'h00FF_FFFF);
        default: ra = 32'h8000_0000 | $urandom;
      endcase
      run_txn(ra, $urandom, 4'($urandom), $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
